// File: rtl/i2c_target.sv
// i2c_target: 7-bit-addressed I2C target with auto-incrementing register pointer behind a register port
// clk       system clock, at least 20x SCL
// reset     asynchronous active-low reset
// scl_in    raw SCL level; sda_in raw SDA level
// sda_oe    1 pulls SDA low, 0 releases it
// reg_addr  register pointer; reg_wdata/reg_we write port; reg_re read strobe sampling reg_rdata
// busy      high from address match until STOP or read NACK
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h53,
  parameter int FILT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);
  localparam int CW = $clog2(FILT) + 1;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_BYTE, RD_ACK} state_t;
  state_t st, st_n;
  logic [1:0] s1, s2, f, fq;
  logic [CW-1:0] fc [2];
  logic [2:0] bc, bc_n;
  logic [6:0] sh, sh_n;
  logic [7:0] tx, tx_n, ptr_n, wd_n, rx;
  logic oe_n, we_n, busy_n, ph, ph_n, rw, rw_n;
  logic scl, sda, rise, fall, start, stop;
  // index 1 is SCL, index 0 is SDA; a new level is accepted only after FILT stable cycles
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1 <= '1;
      s2 <= '1;
      f <= '1;
      fq <= '1;
      fc[0] <= '0;
      fc[1] <= '0;
    end else begin
      s1 <= {scl_in, sda_in};
      s2 <= s1;
      fq <= f;
      for (int i = 0; i < 2; i++)
        if (s2[i] == f[i]) fc[i] <= '0;
        else if (fc[i] == CW'(FILT - 1)) begin
          f[i] <= s2[i];
          fc[i] <= '0;
        end else fc[i] <= fc[i] + 1'b1;
    end
  assign scl = f[1];
  assign sda = f[0];
  assign rise = scl & ~fq[1];
  assign fall = ~scl & fq[1];
  assign start = scl & fq[1] & fq[0] & ~sda;
  assign stop = scl & fq[1] & ~fq[0] & sda;
  assign rx = {sh, sda};
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= IDLE;
      bc <= '0;
      sh <= '0;
      tx <= '0;
      reg_addr <= '0;
      reg_wdata <= '0;
      reg_we <= 1'b0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      ph <= 1'b0;
      rw <= 1'b0;
    end else begin
      st <= st_n;
      bc <= bc_n;
      sh <= sh_n;
      tx <= tx_n;
      reg_addr <= ptr_n;
      reg_wdata <= wd_n;
      reg_we <= we_n;
      sda_oe <= oe_n;
      busy <= busy_n;
      ph <= ph_n;
      rw <= rw_n;
    end
  // ph marks the second half of an ACK slot: first SCL fall drives low, second releases
  always_comb begin
    st_n = st;
    bc_n = bc;
    sh_n = sh;
    tx_n = tx;
    ptr_n = reg_we ? reg_addr + 8'd1 : reg_addr;
    wd_n = reg_wdata;
    we_n = 1'b0;
    oe_n = sda_oe;
    busy_n = busy;
    ph_n = ph;
    rw_n = rw;
    reg_re = 1'b0;
    case (st)
      ADDR, WR_PTR, WR_DATA:
        if (rise) begin
          sh_n = rx[6:0];
          bc_n = bc + 3'd1;
          if (bc == 3'd7) begin
            ph_n = 1'b0;
            if (st == ADDR) begin
              st_n = rx[7:1] == DEV_ADDR ? ADDR_ACK : IDLE;
              busy_n = rx[7:1] == DEV_ADDR;
              rw_n = sda;
            end else if (st == WR_PTR) begin
              ptr_n = rx;
              st_n = WR_ACK;
            end else begin
              wd_n = rx;
              we_n = 1'b1;
              st_n = WR_ACK;
            end
          end
        end
      ADDR_ACK, WR_ACK:
        if (fall) begin
          oe_n = ~ph;
          ph_n = ~ph;
          if (ph) begin
            bc_n = '0;
            if (st == WR_ACK) st_n = WR_DATA;
            else if (!rw) st_n = WR_PTR;
            else begin
              reg_re = 1'b1;
              tx_n = reg_rdata;
              oe_n = ~reg_rdata[7];
              st_n = RD_BYTE;
            end
          end
        end
      RD_BYTE:
        if (fall) begin
          if (bc == 3'd7) begin
            oe_n = 1'b0;
            ptr_n = reg_addr + 8'd1;
            st_n = RD_ACK;
          end else begin
            bc_n = bc + 3'd1;
            tx_n = {tx[6:0], 1'b0};
            oe_n = ~tx[6];
          end
        end
      RD_ACK:
        if (rise && sda) begin
          st_n = IDLE;
          busy_n = 1'b0;
        end else if (fall) begin
          reg_re = 1'b1;
          tx_n = reg_rdata;
          oe_n = ~reg_rdata[7];
          bc_n = '0;
          st_n = RD_BYTE;
        end
      default: ;
    endcase
    if (stop) begin
      st_n = IDLE;
      oe_n = 1'b0;
      busy_n = 1'b0;
      we_n = 1'b0;
      reg_re = 1'b0;
    end else if (start) begin
      st_n = ADDR;
      oe_n = 1'b0;
      bc_n = '0;
      we_n = 1'b0;
      reg_re = 1'b0;
    end
  end
endmodule
